// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

   localparam int unsigned DMEM_WORD_W      = 32;
   localparam int unsigned DMEM_DEF_LATENCY = 2;
   localparam int unsigned DMEM_CNT_W       = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered, read-enabled output.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   we,
   input  logic                   re,
   input  logic [IDX_W-1:0]       idx,
   input  logic [DMEM_WORD_W-1:0] wdata,
   output logic [DMEM_WORD_W-1:0] rdata
);

   logic [DMEM_WORD_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
   end

   // Only the output register is reset; the array contents survive reset.
   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[idx];
   end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder with LATENCY wait states and a one-cycle ack.
// Optional macro DMEM_ALIGN_CHECK_EN flags misaligned addresses as illegal.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = DMEM_DEF_LATENCY
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        memread_i,
   input  logic        memwrite_i,
   input  logic [31:0] memaddr_i,
   input  logic [31:0] writedata_i,
   output logic [31:0] memdata_o,
   output logic        stall_o,
   output logic        ack_o,
   output logic        err_o
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   dmem_state_t            state;
   logic [DMEM_CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]       idx_q;
   logic [DMEM_WORD_W-1:0] wdata_q;
   logic                   rd_q, wr_q, illegal_q;

   logic                   req, illegal_in, enter_done;
   logic                   acc_rd, acc_wr, acc_illegal;
   logic [IDX_W-1:0]       acc_idx;
   logic [DMEM_WORD_W-1:0] acc_wdata;
   logic                   array_we, array_re;
   logic                   addr_unused;

   assign addr_unused = ^{memaddr_i[31:IDX_W+2], memaddr_i[1:0]};

   assign req     = memread_i | memwrite_i;
   assign stall_o = req & ~ack_o;

`ifdef DMEM_ALIGN_CHECK_EN
   assign illegal_in = (memread_i & memwrite_i) | (req & (memaddr_i[1:0] != 2'b00));
`else
   assign illegal_in = memread_i & memwrite_i;
`endif

   // With LATENCY=0 the DONE transition happens in the accept cycle, so the
   // access must come straight from the inputs rather than the request registers.
   always_comb begin
      enter_done  = 1'b0;
      acc_rd      = rd_q;
      acc_wr      = wr_q;
      acc_illegal = illegal_q;
      acc_idx     = idx_q;
      acc_wdata   = wdata_q;
      case (state)
         IDLE: begin
            enter_done  = req && (LATENCY == 0);
            acc_rd      = memread_i;
            acc_wr      = memwrite_i;
            acc_illegal = illegal_in;
            acc_idx     = memaddr_i[IDX_W+1:2];
            acc_wdata   = writedata_i;
         end
         WAIT:    enter_done = (cnt == '0);
         default: enter_done = 1'b0;
      endcase
   end

   assign array_we = ~rst_i & enter_done & acc_wr & ~acc_illegal;
   assign array_re = ~rst_i & enter_done & acc_rd & ~acc_illegal;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk   (clk_i),
      .rst   (rst_i),
      .we    (array_we),
      .re    (array_re),
      .idx   (acc_idx),
      .wdata (acc_wdata),
      .rdata (memdata_o)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         ack_o     <= 1'b0;
         err_o     <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         ack_o <= enter_done;
         err_o <= enter_done & acc_illegal;
         case (state)
            IDLE: begin
               if (req) begin
                  idx_q     <= memaddr_i[IDX_W+1:2];
                  wdata_q   <= writedata_i;
                  rd_q      <= memread_i;
                  wr_q      <= memwrite_i;
                  illegal_q <= illegal_in;
                  if (LATENCY == 0) begin
                     state <= DONE;
                  end else begin
                     state <= WAIT;
                     cnt   <= DMEM_CNT_W'(LATENCY - 1);
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) state <= DONE;
               else           cnt   <= cnt - 1'b1;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with LATENCY=2 and one with LATENCY=0.
module tb_dmem_responder;

   localparam int unsigned LAT_A = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_a, wr_a, rd_b, wr_b;
   logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
   logic [31:0] mdata_a, mdata_b;
   logic        stall_a, ack_a, err_a, stall_b, ack_b, err_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT_A)) dut_a (
      .clk_i(clk), .rst_i(rst), .memread_i(rd_a), .memwrite_i(wr_a),
      .memaddr_i(addr_a), .writedata_i(wdata_a), .memdata_o(mdata_a),
      .stall_o(stall_a), .ack_o(ack_a), .err_o(err_a)
   );

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut_b (
      .clk_i(clk), .rst_i(rst), .memread_i(rd_b), .memwrite_i(wr_b),
      .memaddr_i(addr_b), .writedata_i(wdata_b), .memdata_o(mdata_b),
      .stall_o(stall_b), .ack_o(ack_b), .err_o(err_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Full access on dut_a: stall for LAT_A+1 cycles, ack in the next, then drop.
   task automatic acc_a(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_data);
      @(posedge clk); #1;
      rd_a = rd; wr_a = wr; addr_a = addr; wdata_a = wd;
      for (int c = 0; c <= int'(LAT_A); c++) begin
         @(negedge clk);
         chk({tag, "_stall"}, stall_a, 1);
         chk({tag, "_noack"}, ack_a, 0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk({tag, "_ack"}, ack_a, 1);
      chk({tag, "_stall_ack"}, stall_a, 0);
      chk({tag, "_err"}, err_a, exp_err);
      chk({tag, "_data"}, mdata_a, exp_data);
      @(posedge clk); #1;
      rd_a = 0; wr_a = 0;
      @(negedge clk);
      chk({tag, "_ack_drop"}, ack_a, 0);
      chk({tag, "_err_drop"}, err_a, 0);
   endtask

   initial begin
      rst = 1; rd_a = 0; wr_a = 0; addr_a = '0; wdata_a = '0;
      rd_b = 0; wr_b = 0; addr_b = '0; wdata_b = '0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_data_a", mdata_a, 32'h0);
      chk("rst_ack_a", ack_a, 0);
      chk("rst_err_a", err_a, 0);
      chk("rst_stall_a", stall_a, 0);
      chk("rst_data_b", mdata_b, 32'h0);
      chk("rst_ack_b", ack_b, 0);

      // Write then read back
      acc_a("wr10", 0, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0);
      acc_a("rd10", 1, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF);

      // Illegal rd+wr leaves array and memdata untouched
      acc_a("wr20", 0, 1, 32'h20, 32'hCAFE0001, 0, 32'hDEADBEEF);
      acc_a("rd10b", 1, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF);
      acc_a("ill20", 1, 1, 32'h20, 32'h1234, 1, 32'hDEADBEEF);
      acc_a("rd20", 1, 0, 32'h20, 32'h0, 0, 32'hCAFE0001);

      // Address wrap: 0x400 aliases word 0
      acc_a("wr400", 0, 1, 32'h400, 32'h5A5A5A5A, 0, 32'hCAFE0001);
      acc_a("rd000", 1, 0, 32'h000, 32'h0, 0, 32'h5A5A5A5A);

      // Reset during WAIT aborts the write
      acc_a("wr30", 0, 1, 32'h30, 32'h11112222, 0, 32'h5A5A5A5A);
      @(posedge clk); #1;
      rd_a = 0; wr_a = 1; addr_a = 32'h30; wdata_a = 32'hFFFFFFFF;
      @(negedge clk);
      chk("abort_stall", stall_a, 1);
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0; wr_a = 0;
      @(negedge clk);
      chk("abort_data_rst", mdata_a, 32'h0);
      chk("abort_stall_idle", stall_a, 0);
      for (int c = 0; c < 4; c++) begin
         chk("abort_no_ack", ack_a, 0);
         @(negedge clk);
      end
      acc_a("rd30", 1, 0, 32'h30, 32'h0, 0, 32'h11112222);

      // Misaligned write to 0x13
      acc_a("wr10c", 0, 1, 32'h10, 32'h01010101, 0, 32'h11112222);
`ifdef DMEM_ALIGN_CHECK_EN
      acc_a("wr13", 0, 1, 32'h13, 32'h77777777, 1, 32'h11112222);
      acc_a("rd10c", 1, 0, 32'h10, 32'h0, 0, 32'h01010101);
`else
      acc_a("wr13", 0, 1, 32'h13, 32'h77777777, 0, 32'h11112222);
      acc_a("rd10c", 1, 0, 32'h10, 32'h0, 0, 32'h77777777);
`endif

      // LATENCY=0: write, then read accepted in the cycle after its ack
      @(posedge clk); #1;
      wr_b = 1; addr_b = 32'h8; wdata_b = 32'hA5A5A5A5;
      @(negedge clk);
      chk("b_wr_stall", stall_b, 1);
      chk("b_wr_noack", ack_b, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("b_wr_ack", ack_b, 1);
      chk("b_wr_stall_ack", stall_b, 0);
      chk("b_wr_err", err_b, 0);
      @(posedge clk); #1;
      wr_b = 0; rd_b = 1; addr_b = 32'h8;
      @(negedge clk);
      chk("b_rd_stall", stall_b, 1);
      chk("b_rd_noack", ack_b, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("b_rd_ack", ack_b, 1);
      chk("b_rd_stall_ack", stall_b, 0);
      chk("b_rd_data", mdata_b, 32'hA5A5A5A5);
      @(posedge clk); #1;
      rd_b = 0;
      @(negedge clk);
      chk("b_rd_ack_drop", ack_b, 0);
      chk("b_rd_data_hold", mdata_b, 32'hA5A5A5A5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
